fft_pwr_capture: RTL and testbench

Parametrised per-bin power capture and averaging stage between the FFT power outputs and the readout path. Each frame it accepts one vector of NUM_BINS power values and averages 2^AVG_LOG2 frames. It publishes the averaged bins over a valid/ready stream and reports the peak bin. It replaces the fixed 17-bin, free-running power taps with a flow-controlled, frame-aligned, loss-reporting interface.

---
 rtl/fft_pwr_capture_if.sv | 15 +
 rtl/fft_pwr_capture.sv | 148 ++++++++++++++
 tb/tb_fft_pwr_capture.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pwr_capture_if.sv
// Readout stream of averaged FFT bin powers.
// The capture stage (master) drives valid/bin/power/last and the consumer (slave) drives ready.
interface fft_pwr_capture_if #(
  parameter int PWR_W = 35,
  parameter int IDX_W = 5
);
  logic             rd_valid;
  logic             rd_ready;
  logic [IDX_W-1:0] rd_bin;
  logic [PWR_W-1:0] rd_pwr;
  logic             rd_last;

  modport master (output rd_valid, rd_bin, rd_pwr, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_bin, rd_pwr, rd_last, output rd_ready);
endinterface

// File: rtl/fft_pwr_capture.sv
// Per-bin FFT power averaging over 2^AVG_LOG2 frames, with a flow-controlled drain of each set,
// peak-bin reporting and a saturating count of sets lost while the drain was busy.
module fft_pwr_capture #(
  parameter int NUM_BINS = 17,
  parameter int PWR_W    = 35,
  parameter int AVG_LOG2 = 2,
  localparam int IDX_W   = $clog2(NUM_BINS)
) (
  input  logic                      clk_lvds,
  input  logic                      reset,
  input  logic                      freeze,
  input  logic                      frame_valid,
  input  logic [NUM_BINS*PWR_W-1:0] pwr_in,
  fft_pwr_capture_if.master         rd,
  output logic [IDX_W-1:0]          peak_bin,
  output logic [PWR_W-1:0]          peak_pwr,
  output logic                      peak_valid,
  output logic [7:0]                drop_cnt
);

  localparam int ACC_W = PWR_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NUM_BINS - 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [ACC_W-1:0] acc_q [NUM_BINS];
  logic [CNT_W-1:0] cnt_q;
  logic [PWR_W-1:0] res_q [NUM_BINS];
  logic [PWR_W-1:0] res_d [NUM_BINS];
  logic [IDX_W-1:0] peak_bin_q, peak_bin_d;
  logic [PWR_W-1:0] peak_pwr_q, peak_pwr_d;
  logic             peak_valid_q;
  logic [7:0]       drop_q;
  logic             accept, complete, latch;

  function automatic logic [PWR_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    avg_trunc = PWR_W'(sum >> AVG_LOG2);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept   = frame_valid && !freeze;
  assign complete = accept && ((AVG_LOG2 == 0) || (cnt_q == {CNT_W{1'b1}}));
  assign latch    = complete && (state_q == S_IDLE);

  // Completing frame is folded in directly so the set latches on the same edge.
  always_comb begin
    res_d      = '{default: '0};
    peak_bin_d = '0;
    peak_pwr_d = '0;
    for (int k = 0; k < NUM_BINS; k++) begin
      res_d[k] = avg_trunc(acc_q[k] + ACC_W'(pwr_in[k*PWR_W +: PWR_W]));
      if (k == 0 || res_d[k] > peak_pwr_d) begin
        peak_bin_d = IDX_W'(k);
        peak_pwr_d = res_d[k];
      end
    end
  end

  // Accumulation stage, independent of the drain
  always_ff @(posedge clk_lvds) begin
    if (reset || complete) begin
      cnt_q <= '0;
      for (int k = 0; k < NUM_BINS; k++) acc_q[k] <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
      for (int k = 0; k < NUM_BINS; k++)
        acc_q[k] <= acc_q[k] + ACC_W'(pwr_in[k*PWR_W +: PWR_W]);
    end
  end

  // Result bank and peak/drop reporting
  always_ff @(posedge clk_lvds) begin
    if (latch) begin
      for (int k = 0; k < NUM_BINS; k++) res_q[k] <= res_d[k];
    end
  end

  always_ff @(posedge clk_lvds) begin
    if (reset) begin
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_pwr_q   <= '0;
      drop_q       <= '0;
    end else begin
      if (latch) begin
        peak_valid_q <= 1'b1;
        peak_bin_q   <= peak_bin_d;
        peak_pwr_q   <= peak_pwr_d;
      end
      if (complete && state_q == S_DRAIN) drop_q <= sat_inc8(drop_q);
    end
  end

  // Drain FSM
  always_ff @(posedge clk_lvds) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (latch) begin
          state_d = S_DRAIN;
          ptr_d   = '0;
        end
      end
      S_DRAIN: begin
        if (rd.rd_ready) begin
          if (ptr_q == LAST_BIN) begin
            state_d = S_IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign rd.rd_valid = (state_q == S_DRAIN);
  assign rd.rd_bin   = ptr_q;
  assign rd.rd_pwr   = (state_q == S_DRAIN) ? res_q[ptr_q] : '0;
  assign rd.rd_last  = (state_q == S_DRAIN) && (ptr_q == LAST_BIN);

  assign peak_bin   = peak_bin_q;
  assign peak_pwr   = peak_pwr_q;
  assign peak_valid = peak_valid_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fft_pwr_capture.sv
// Scoreboard bench: a 17-bin, 4-frame averaging instance plus a 5-bin instance with no averaging.
module tb_fft_pwr_capture;
  localparam int NB  = 17;
  localparam int PW  = 35;
  localparam int AL  = 2;
  localparam int IW  = $clog2(NB);
  localparam int NB1 = 5;
  localparam int IW1 = $clog2(NB1);

  typedef logic [PW-1:0] pwr_t;
  typedef struct {
    int   bin;
    pwr_t pwr;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, freeze, fv;
  logic [NB*PW-1:0]    pin;
  logic [IW-1:0]       pk_bin;
  pwr_t                pk_pwr;
  logic                pk_vld;
  logic [7:0]          drop;

  logic                freeze1, fv1;
  logic [NB1*PW-1:0]   pin1;
  logic [IW1-1:0]      pk_bin1;
  pwr_t                pk_pwr1;
  logic                pk_vld1;
  logic [7:0]          drop1;

  fft_pwr_capture_if #(.PWR_W(PW), .IDX_W(IW))  rd0 ();
  fft_pwr_capture_if #(.PWR_W(PW), .IDX_W(IW1)) rd1 ();

  fft_pwr_capture #(.NUM_BINS(NB), .PWR_W(PW), .AVG_LOG2(AL)) dut0 (
    .clk_lvds(clk), .reset(rst), .freeze(freeze), .frame_valid(fv), .pwr_in(pin),
    .rd(rd0), .peak_bin(pk_bin), .peak_pwr(pk_pwr), .peak_valid(pk_vld), .drop_cnt(drop));

  fft_pwr_capture #(.NUM_BINS(NB1), .PWR_W(PW), .AVG_LOG2(0)) dut1 (
    .clk_lvds(clk), .reset(rst), .freeze(freeze1), .frame_valid(fv1), .pwr_in(pin1),
    .rd(rd1), .peak_bin(pk_bin1), .peak_pwr(pk_pwr1), .peak_valid(pk_vld1), .drop_cnt(drop1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the averaging instance
  pwr_t             fr [NB];
  pwr_t             fr1 [NB1];
  logic [PW+AL-1:0] m_acc [NB];
  int               m_cnt;
  logic [7:0]       m_drop;
  int               m_pk_bin;
  pwr_t             m_pk_pwr;
  exp_t             sb [$];

  task automatic model_clear();
    for (int k = 0; k < NB; k++) m_acc[k] = '0;
    m_cnt  = 0;
    m_drop = '0;
    sb.delete();
  endtask

  task automatic send0();
    logic             latched;
    logic [PW+AL-1:0] s;
    pwr_t             r;
    exp_t             e;
    latched = 1'b0;
    for (int k = 0; k < NB; k++) pin[k*PW +: PW] = fr[k];
    fv = 1'b1;
    if (!freeze) begin
      if (m_cnt == (1 << AL) - 1) begin
        if (sb.size() == 0) begin
          latched = 1'b1;
          for (int k = 0; k < NB; k++) begin
            s = m_acc[k] + (PW+AL)'(fr[k]);
            r = pwr_t'(s >> AL);
            if (k == 0 || r > m_pk_pwr) begin
              m_pk_bin = k;
              m_pk_pwr = r;
            end
            e.bin = k; e.pwr = r; e.last = (k == NB - 1);
            sb.push_back(e);
          end
        end else if (m_drop != 8'hFF) begin
          m_drop++;
        end
        for (int k = 0; k < NB; k++) m_acc[k] = '0;
        m_cnt = 0;
      end else begin
        for (int k = 0; k < NB; k++) m_acc[k] = m_acc[k] + (PW+AL)'(fr[k]);
        m_cnt++;
      end
    end
    @(posedge clk); #1;
    fv = 1'b0;
    if (latched) begin
      chk("peak_valid", pk_vld, 1);
      chk("peak_bin", pk_bin, m_pk_bin);
      chk("peak_pwr", pk_pwr, m_pk_pwr);
      chk("first_valid", rd0.rd_valid, 1);
      chk("first_bin", rd0.rd_bin, 0);
    end
    chk("drop_cnt", drop, m_drop);
  endtask

  task automatic wait_drain(input int mode, input int budget, output int cyc);
    cyc = 0;
    while ((sb.size() != 0 || rd0.rd_valid !== 1'b0) && cyc < budget) begin
      case (mode)
        0:       rd0.rd_ready = 1'b1;
        1:       rd0.rd_ready = (cyc % 3 == 0);
        default: rd0.rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    rd0.rd_ready = 1'b1;
    chk("drain_done", 64'((sb.size() == 0) && (rd0.rd_valid === 1'b0)), 1);
  endtask

  function automatic pwr_t rnd_pwr();
    return pwr_t'({$urandom(), $urandom()});
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks stability while stalled
  logic          st_prev = 1'b0;
  logic [IW-1:0] st_bin;
  pwr_t          st_pwr;
  logic          st_last;
  exp_t          mon_e;

  initial forever begin
    @(negedge clk);
    if (st_prev) begin
      chk("stall_valid", rd0.rd_valid, 1);
      chk("stall_bin", rd0.rd_bin, st_bin);
      chk("stall_pwr", rd0.rd_pwr, st_pwr);
      chk("stall_last", rd0.rd_last, st_last);
    end
    st_prev = rd0.rd_valid && !rd0.rd_ready && !rst;
    st_bin  = rd0.rd_bin;
    st_pwr  = rd0.rd_pwr;
    st_last = rd0.rd_last;
    if (rd0.rd_valid && rd0.rd_ready && !rst) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_bin", rd0.rd_bin, mon_e.bin);
        chk("rd_pwr", rd0.rd_pwr, mon_e.pwr);
        chk("rd_last", rd0.rd_last, mon_e.last);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int   cyc;
  int   exp_pk;
  pwr_t big;

  initial begin
    rst = 1'b1; freeze = 1'b0; fv = 1'b0; pin = '0;
    freeze1 = 1'b0; fv1 = 1'b0; pin1 = '0;
    rd0.rd_ready = 1'b1; rd1.rd_ready = 1'b1;
    m_pk_bin = 0; m_pk_pwr = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", rd0.rd_valid, 0);
    chk("rst_bin", rd0.rd_bin, 0);
    chk("rst_pwr", rd0.rd_pwr, 0);
    chk("rst_last", rd0.rd_last, 0);
    chk("rst_peak_valid", pk_vld, 0);
    chk("rst_drop", drop, 0);
    chk("rst1_valid", rd1.rd_valid, 0);

    // Averaging: bin k = 4k+j over four frames
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NB; k++) fr[k] = pwr_t'(4*k + j);
      send0();
    end
    chk("avg_peak_bin", pk_bin, 16);
    chk("avg_peak_pwr", pk_pwr, 65);
    wait_drain(0, 100, cyc);
    chk("drain_cycles", cyc, NB);

    // Backpressure with ready pattern 1,0,0
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NB; k++) fr[k] = rnd_pwr();
      send0();
    end
    wait_drain(1, 200, cyc);

    // Drop: first set held, two more sets discarded
    rd0.rd_ready = 1'b0;
    for (int j = 0; j < 12; j++) begin
      for (int k = 0; k < NB; k++) fr[k] = pwr_t'($urandom_range(0, 1000));
      send0();
    end
    chk("drop_two", drop, 2);
    chk("hold_bin", rd0.rd_bin, 0);
    chk("hold_pwr", rd0.rd_pwr, sb[0].pwr);
    wait_drain(0, 100, cyc);

    // Freeze over frames 2-3, then freeze during drain
    for (int j = 0; j < 6; j++) begin
      freeze = (j == 1 || j == 2);
      for (int k = 0; k < NB; k++) fr[k] = pwr_t'($urandom_range(0, 5000));
      send0();
    end
    freeze = 1'b1;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < NB; k++) fr[k] = rnd_pwr();
      send0();
    end
    freeze = 1'b0;
    wait_drain(0, 100, cyc);
    chk("freeze_no_drop", drop, 2);

    // Ties at full scale
    big = '1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NB; k++) fr[k] = big;
      send0();
    end
    chk("tie_peak_bin", pk_bin, 0);
    chk("tie_rd_pwr", rd0.rd_pwr, 64'h7_FFFF_FFFF);
    wait_drain(0, 100, cyc);

    // Reset mid-drain with a partial set accumulated
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < NB; k++) fr[k] = rnd_pwr();
      send0();
    end
    for (int i = 0; i < 40 && !(rd0.rd_valid && rd0.rd_bin == 5); i++) @(negedge clk);
    chk("saw_bin5", rd0.rd_bin, 5);
    rst = 1'b1;
    fv = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; fv = 1'b0;
    model_clear();
    chk("rrst_valid", rd0.rd_valid, 0);
    chk("rrst_bin", rd0.rd_bin, 0);
    chk("rrst_pwr", rd0.rd_pwr, 0);
    chk("rrst_last", rd0.rd_last, 0);
    chk("rrst_peak_valid", pk_vld, 0);
    chk("rrst_peak_bin", pk_bin, 0);
    chk("rrst_peak_pwr", pk_pwr, 0);
    chk("rrst_drop", drop, 0);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NB; k++) fr[k] = rnd_pwr();
      send0();
    end
    wait_drain(0, 100, cyc);

    // Random sets with random ready
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 4; j++) begin
        for (int k = 0; k < NB; k++) fr[k] = rnd_pwr();
        send0();
      end
      wait_drain(2, 400, cyc);
    end

    // No-averaging instance: 1-cycle reflection and drop saturation
    rd1.rd_ready = 1'b0;
    exp_pk = 0;
    for (int k = 0; k < NB1; k++) begin
      fr1[k] = rnd_pwr();
      pin1[k*PW +: PW] = fr1[k];
      if (fr1[k] > fr1[exp_pk]) exp_pk = k;
    end
    fv1 = 1'b1;
    @(posedge clk); #1;
    fv1 = 1'b0;
    chk("a0_valid", rd1.rd_valid, 1);
    chk("a0_bin", rd1.rd_bin, 0);
    chk("a0_pwr", rd1.rd_pwr, fr1[0]);
    chk("a0_peak_bin", pk_bin1, exp_pk);
    chk("a0_peak_pwr", pk_pwr1, fr1[exp_pk]);
    fv1 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pin1 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      if (i == 0) chk("a0_drop_first", drop1, 1);
    end
    fv1 = 1'b0;
    chk("a0_drop_sat", drop1, 255);
    chk("a0_hold_pwr", rd1.rd_pwr, fr1[0]);
    rd1.rd_ready = 1'b1;
    for (int b = 0; b < NB1; b++) begin
      chk("a0_drain_bin", rd1.rd_bin, b);
      chk("a0_drain_pwr", rd1.rd_pwr, fr1[b]);
      chk("a0_drain_last", rd1.rd_last, (b == NB1 - 1));
      @(posedge clk); #1;
    end
    chk("a0_idle", rd1.rd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
